demux1_2: RTL and testbench
===========================

# demux1_2

Packet-aware 1-to-2 stream demultiplexer; the inverse of the team's 2:1 select path. Accepts one valid/ready input stream and steers each complete packet to output 0 or output 1 according to `select`, sampled on the packet's first beat. Each output has a one-entry pipeline register, so every beat incurs one cycle of latency. It sits wherever a shared stream fans out to two consumers.

## Interface
- `WIDTH`, 8, data width in bits
- `clk`  input  1  rising-edge clock, single clock domain
- `rst`  input  1  synchronous, active-high reset
- `in_data`  input  WIDTH  input beat payload
- `in_valid`  input  1  input beat valid
- `in_last`  input  1  final beat of packet
- `in_ready`  output  1  input beat accepted when `in_valid && in_ready`
- `select`  input  1  destination (0 → out0, 1 → out1); sampled only on the first beat of a packet
- `out0_data` / `out1_data`  output  WIDTH  routed payload
- `out0_valid` / `out1_valid`  output  1  output beat valid
- `out0_last` / `out1_last`  output  1  final beat of routed packet
- `out0_ready` / `out1_ready`  input  1  downstream accept
- `pkt_cnt0` / `pkt_cnt1`  output  16  completed-packet counters; present only with `DEMUX1_2_CNT_EN`

## Operation
- FSM states: IDLE (awaiting first beat), BUSY (mid-packet).
- IDLE: the destination is `select`. On an accepted beat, latch `select` into `route_sel`. If `in_last=0`, go to BUSY; if `in_last=1` (single-beat packet), stay in IDLE.
- BUSY: the destination is `route_sel`, and `select` is ignored. An accepted beat with `in_last=1` returns the FSM to IDLE.
- Output register n: holds `{data,last}` and `valid`. It loads on an accepted beat routed to n. It clears `valid` when `outn_valid && outn_ready` and no new load occurs in that cycle.
- `in_ready` = destination register empty OR (destination `outn_ready`=1); this gives full throughput of one beat per cycle. The non-destination output never affects `in_ready`.
- Beats are never duplicated, dropped or reordered. A packet never splits across outputs.
- Output n's data and last hold stable while `outn_valid=1 && outn_ready=0`.

## Timing
- Latency: a beat accepted at edge k is visible on `outn_*` after edge k.
- Reset (sync, `rst=1` at edge): state=IDLE, `route_sel`=0, `out0_valid`=`out1_valid`=0, data/last registers=0, counters=0. `in_ready` after reset = 1.
- Reset mid-packet aborts the packet: any held beats are discarded, and the next accepted beat is treated as a first beat.
- Simultaneous drain and load on the same output in one cycle: `valid` stays 1 and the register takes the new beat.
- A `select` change during BUSY has no effect until the next first beat.
- `in_valid=0` in BUSY: the FSM holds in BUSY indefinitely.

## Configuration
- `DEMUX1_2_CNT_EN` defined: `pkt_cnt0`/`pkt_cnt1` exist. Each counter increments by 1 when its output completes a beat with `last=1` (`valid && ready && last`). Each wraps 0xFFFF → 0x0000.
- Not defined: both ports and both counters are absent, and routing behaviour is identical.

## Structure
- Package `demux_pkg`: state typedef (IDLE, BUSY), default width constant `DEMUX_WIDTH=8`, counter width constant `PKT_CNT_W=16`.
- Sub-module `stream_reg`: one-entry valid/ready register with load/drain logic, instantiated once per output. FSM, routing and counters live in the top level.

## Test plan
- After reset: `in_ready=1`, both out valids and `pkt_cnt0`/`pkt_cnt1` = 0.
- 3-beat packet 0x11, 0x22, 0x33 (last on 0x33) with `select=1` on beat 1, then `select` toggled to 0 mid-packet, outputs always ready → all three beats appear on out1 in order, 1 cycle late; out0 stays idle.
- Back-to-back single-beat packets 0xA0 (sel=0) and 0xB1 (sel=1) on consecutive cycles → 0xA0 on out0 at cycle+1 and 0xB1 on out1 at cycle+2; `in_ready` stays 1 throughout.
- Output 0 stalled (`out0_ready=0`) with out0 register full, routed beat pending → `in_ready=0` and `out0_data` held stable. On release, the pending beat is accepted the same cycle and the register reloads with `valid` continuously 1.
- `rst` asserted after beat 2 of a 4-beat packet to out1 → out1_valid=0 next cycle. The next beat with `select=0` routes to out0.
- With `DEMUX1_2_CNT_EN`: 65537 single-beat packets to out0 → `pkt_cnt0`=1 after wrap, `pkt_cnt1`=0.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared types and constants for the demux1_2 stream
//                demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Packet-tracking FSM: IDLE waits for a first beat, BUSY is mid-packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEMUX_WIDTH = 8;
    localparam int PKT_CNT_W   = 16;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux1_2_stream_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_2_stream_reg
//  Description : One-entry valid/ready pipeline register. Loads a beat when
//                told to, and empties when the consumer takes the held beat
//                with no new beat arriving in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1_2_stream_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_can_load
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;

    // Load has priority over drain, so a same-cycle drain+load keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_last     = r_last;
    // Space exists if empty, or if the held beat leaves this cycle.
    assign o_can_load = ~r_valid | i_ready;

endmodule : demux1_2_stream_reg
`default_nettype wire

// File: rtl/demux1_2.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_2
//  Description : Packet-aware 1-to-2 valid/ready stream demultiplexer. The
//                destination is taken from select on a packet's first beat
//                and held for the rest of the packet. Each output has a
//                one-entry register (one cycle latency).
//                Optional macro DEMUX1_2_CNT_EN adds per-output completed
//                packet counters pkt_cnt0/pkt_cnt1.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1_2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 select,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out0_valid,
    output logic                 out0_last,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic                 out1_valid,
    output logic                 out1_last,
    input  logic                 out1_ready
`ifdef DEMUX1_2_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0] pkt_cnt0,
    output logic [PKT_CNT_W-1:0] pkt_cnt1
`endif
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_route_sel;
    logic   w_dest;
    logic   w_accept;
    logic   w_can_load0;
    logic   w_can_load1;
    logic   w_load0;
    logic   w_load1;

    // First beat follows select directly; later beats follow the latched route.
    assign w_dest   = (r_state == IDLE) ? select : r_route_sel;
    // Only the destination register can back-pressure the input.
    assign in_ready = w_dest ? w_can_load1 : w_can_load0;
    assign w_accept = in_valid & in_ready;
    assign w_load0  = w_accept & ~w_dest;
    assign w_load1  = w_accept &  w_dest;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter BUSY on a multi-beat first beat, leave on the last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !in_last) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_accept && in_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the destination on every accepted first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_route_sel <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_route_sel <= select;
        end
    end

    demux1_2_stream_reg #(.WIDTH(WIDTH)) u_reg0 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load0),
        .i_data     (in_data),
        .i_last     (in_last),
        .i_ready    (out0_ready),
        .o_valid    (out0_valid),
        .o_data     (out0_data),
        .o_last     (out0_last),
        .o_can_load (w_can_load0)
    );

    demux1_2_stream_reg #(.WIDTH(WIDTH)) u_reg1 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load1),
        .i_data     (in_data),
        .i_last     (in_last),
        .i_ready    (out1_ready),
        .o_valid    (out1_valid),
        .o_data     (out1_data),
        .o_last     (out1_last),
        .o_can_load (w_can_load1)
    );

`ifdef DEMUX1_2_CNT_EN
    logic [PKT_CNT_W-1:0] r_pkt_cnt0;
    logic [PKT_CNT_W-1:0] r_pkt_cnt1;

    // Count packets as their last beat leaves each output; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready && out0_last) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
            end
            if (out1_valid && out1_ready && out1_last) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
            end
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule : demux1_2
`default_nettype wire

// File: tb/tb_demux1_2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1_2
//  Description : Directed self-checking bench for demux1_2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1_2;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         select;
    logic [W-1:0] out0_data;
    logic         out0_valid;
    logic         out0_last;
    logic         out0_ready;
    logic [W-1:0] out1_data;
    logic         out1_valid;
    logic         out1_last;
    logic         out1_ready;
`ifdef DEMUX1_2_CNT_EN
    logic [15:0]  pkt_cnt0;
    logic [15:0]  pkt_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux1_2 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .select     (select),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_last  (out0_last),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_last  (out1_last),
        .out1_ready (out1_ready)
`ifdef DEMUX1_2_CNT_EN
        ,
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
`endif
    );

    // Drive one beat at the falling edge (inputs settle well before posedge).
    task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic s);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        select   = s;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; select = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %b exp 0", out0_valid); end
        checks++;
        if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b exp 0", out1_valid); end
        checks++;
        if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h/%h exp 00/00", out0_data, out1_data);
        end
`ifdef DEMUX1_2_CNT_EN
        checks++;
        if (pkt_cnt0 !== 16'h0 || pkt_cnt1 !== 16'h0) begin
            errors++; $display("FAIL reset_cnt got %h/%h exp 0/0", pkt_cnt0, pkt_cnt1);
        end
`endif
    endtask

    // 3-beat packet to out1; select flips to 0 mid-packet and must be ignored.
    task automatic test_packet_route();
        logic [W-1:0] exp_d [3];
        logic         exp_l [3];
        logic         sel_v [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
        sel_v[0] = 1'b1;  sel_v[1] = 1'b0;  sel_v[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, exp_d[i], exp_l[i], sel_v[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL pkt_in_ready beat %0d got %b exp 1", i, in_ready); end
            edge_sample();
            checks++;
            if (out1_valid !== 1'b1 || out1_data !== exp_d[i] || out1_last !== exp_l[i]) begin
                errors++;
                $display("FAIL pkt_out1 beat %0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         i, out1_valid, out1_data, out1_last, exp_d[i], exp_l[i]);
            end
            checks++;
            if (out0_valid !== 1'b0) begin errors++; $display("FAIL pkt_out0_idle beat %0d got %b exp 0", i, out0_valid); end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        edge_sample();
        checks++;
        if (out1_valid !== 1'b0) begin errors++; $display("FAIL pkt_drain got %b exp 0", out1_valid); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'hA0, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a got %b exp 1", in_ready); end
        edge_sample();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'hA0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_a got v0=%b d0=%h v1=%b exp 1 a0 0", out0_valid, out0_data, out1_valid);
        end
        drive(1'b1, 8'hB1, 1'b1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_b got %b exp 1", in_ready); end
        edge_sample();
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'hB1 || out0_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_b got v1=%b d1=%h v0=%b exp 1 b1 0", out1_valid, out1_data, out0_valid);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        edge_sample();
    endtask

    task automatic test_stall();
        out0_ready = 1'b0;
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        edge_sample();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h55) begin
            errors++; $display("FAIL stall_load got v=%b d=%h exp 1 55", out0_valid, out0_data);
        end
        drive(1'b1, 8'h66, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
        edge_sample();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h55) begin
            errors++; $display("FAIL stall_hold got v=%b d=%h exp 1 55", out0_valid, out0_data);
        end
        @(negedge clk);
        out0_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
        edge_sample();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h66) begin
            errors++; $display("FAIL stall_reload got v=%b d=%h exp 1 66", out0_valid, out0_data);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        edge_sample();
        checks++;
        if (out0_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out0_valid); end
    endtask

    task automatic test_reset_mid_packet();
        drive(1'b1, 8'h01, 1'b0, 1'b1);
        edge_sample();
        drive(1'b1, 8'h02, 1'b0, 1'b1);
        edge_sample();
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h02) begin
            errors++; $display("FAIL rstmid_beat2 got v=%b d=%h exp 1 02", out1_valid, out1_data);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        edge_sample();
        checks++;
        if (out1_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out1_valid got %b exp 0", out1_valid); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h0A, 1'b1, 1'b0);
        edge_sample();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h0A || out1_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_reroute got v0=%b d0=%h v1=%b exp 1 0a 0", out0_valid, out0_data, out1_valid);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        edge_sample();
    endtask

`ifdef DEMUX1_2_CNT_EN
    task automatic test_counter_wrap();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out0_ready = 1'b1;
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        repeat (65537) @(posedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        edge_sample();
        checks++;
        if (pkt_cnt0 !== 16'h0001) begin errors++; $display("FAIL cnt0_wrap got %h exp 0001", pkt_cnt0); end
        checks++;
        if (pkt_cnt1 !== 16'h0000) begin errors++; $display("FAIL cnt1_idle got %h exp 0000", pkt_cnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_packet_route();
        test_back_to_back();
        test_stall();
        test_reset_mid_packet();
`ifdef DEMUX1_2_CNT_EN
        test_counter_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux1_2
`default_nettype wire
